// File: rtl/ibex_bp_redirect_ctrl.sv
// Static branch predictor sequencing: issues predicted redirects to the
// prefetch buffer, tracks predictions in order, and flushes on mispredicts.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   fetch_*                fetched instruction handshake and attributes
//   predict_taken_i/pc_i   predictor decision for the fetched instruction
//   redirect_o/pc_o        redirect request held until redirect_ready_i
//   resolve_*              outcome of the oldest tracked instruction
//   kill_i                 external flush, clears tracking without flush_o
//   flush_o/flush_pc_o     one-cycle mispredict flush and recovery PC
//   perf_*_cnt_o           saturating counters
//
// Optional feature: define IBEX_BP_PERF_CNT_EN to build the counters;
// otherwise both counter outputs are tied to zero.
module ibex_bp_redirect_ctrl #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_valid_i,
    output logic             fetch_ready_o,
    input  logic [31:0]      fetch_pc_i,
    input  logic             fetch_compressed_i,
    input  logic             predict_taken_i,
    input  logic [31:0]      predict_pc_i,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    input  logic             redirect_ready_i,
    input  logic             resolve_valid_i,
    input  logic             resolve_taken_i,
    input  logic [31:0]      resolve_target_i,
    input  logic             kill_i,
    output logic             flush_o,
    output logic [31:0]      flush_pc_o,
    output logic [CNT_W-1:0] perf_pred_cnt_o,
    output logic [CNT_W-1:0] perf_mispred_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    typedef enum logic {
        RUN,
        REDIRECT
    } state_e;

    state_e state_q, state_d;

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PW:0]      wptr_q, rptr_q;
    logic [DEPTH-1:0] q_taken;
    logic [31:0]      q_target [DEPTH];
    logic [31:0]      q_fall   [DEPTH];

    logic [PW-1:0] head;
    logic          empty, full;
    logic          accept, push, pop;
    logic          mispredict, clear;
    logic [31:0]   fallthrough;
    logic [31:0]   redirect_pc_q;
    logic          flush_q;
    logic [31:0]   flush_pc_q;

    assign head  = rptr_q[PW-1:0];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW] != rptr_q[PW]) &&
                   (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

    // Ready looks only at registered state: a same-cycle pop never
    // frees a slot for a same-cycle push.
    assign fetch_ready_o = (state_q == RUN) && !full;
    assign accept        = fetch_valid_i && fetch_ready_o;
    assign pop           = resolve_valid_i && !empty;

    assign mispredict = pop &&
        ((resolve_taken_i != q_taken[head]) ||
         (resolve_taken_i && (resolve_target_i != q_target[head])));

    // Anything younger than a mispredict or a kill is wrong-path.
    assign clear = kill_i || mispredict;
    assign push  = accept && !clear;

    assign fallthrough = fetch_pc_i +
                         (fetch_compressed_i ? 32'd2 : 32'd4);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (push && predict_taken_i) state_d = REDIRECT;
            REDIRECT: if (redirect_ready_i) state_d = RUN;
            default:  state_d = RUN;
        endcase
        if (clear) state_d = RUN;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_taken[wptr_q[PW-1:0]]  <= predict_taken_i;
            q_target[wptr_q[PW-1:0]] <= predict_pc_i;
            q_fall[wptr_q[PW-1:0]]   <= fallthrough;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redirect_pc_q <= '0;
        end else if (push && predict_taken_i) begin
            redirect_pc_q <= predict_pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            flush_q <= mispredict && !kill_i;
            if (mispredict && !kill_i) begin
                flush_pc_q <= resolve_taken_i ? resolve_target_i
                                              : q_fall[head];
            end
        end
    end

    assign redirect_o    = (state_q == REDIRECT);
    assign redirect_pc_o = redirect_pc_q;
    assign flush_o       = flush_q;
    assign flush_pc_o    = flush_pc_q;

`ifdef IBEX_BP_PERF_CNT_EN
    logic [CNT_W-1:0] pred_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (pop && !(&pred_cnt_q))
                pred_cnt_q <= pred_cnt_q + CNT_W'(1);
            // Counted even when kill_i suppresses the flush.
            if (mispredict && !(&mispred_cnt_q))
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

    assign perf_pred_cnt_o    = pred_cnt_q;
    assign perf_mispred_cnt_o = mispred_cnt_q;
`else
    assign perf_pred_cnt_o    = '0;
    assign perf_mispred_cnt_o = '0;
`endif

    // A resolve with nothing tracked is dropped; it indicates an
    // upstream sequencing bug.
    resolve_on_empty_a : assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(resolve_valid_i && empty)
    );

endmodule

// File: tb/tb_ibex_bp_redirect_ctrl.sv
// Self-checking bench for ibex_bp_redirect_ctrl (DEPTH=2, CNT_W=4).
// Flush expectations go through a scoreboard queue.
module tb_ibex_bp_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_pc_i;
    logic        fetch_compressed_i;
    logic        predict_taken_i;
    logic [31:0] predict_pc_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;
    logic        resolve_valid_i;
    logic        resolve_taken_i;
    logic [31:0] resolve_target_i;
    logic        kill_i;
    logic        flush_o;
    logic [31:0] flush_pc_o;
    logic [3:0]  perf_pred_cnt_o;
    logic [3:0]  perf_mispred_cnt_o;

    typedef struct {
        logic        fl;
        logic [31:0] pc;
    } fl_t;

    fl_t sbq[$];
    int  errors = 0;
    int  checks = 0;
    int  pred_m = 0;
    int  mis_m  = 0;

    ibex_bp_redirect_ctrl #(.DEPTH(2), .CNT_W(4)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .fetch_valid_i      (fetch_valid_i),
        .fetch_ready_o      (fetch_ready_o),
        .fetch_pc_i         (fetch_pc_i),
        .fetch_compressed_i (fetch_compressed_i),
        .predict_taken_i    (predict_taken_i),
        .predict_pc_i       (predict_pc_i),
        .redirect_o         (redirect_o),
        .redirect_pc_o      (redirect_pc_o),
        .redirect_ready_i   (redirect_ready_i),
        .resolve_valid_i    (resolve_valid_i),
        .resolve_taken_i    (resolve_taken_i),
        .resolve_target_i   (resolve_target_i),
        .kill_i             (kill_i),
        .flush_o            (flush_o),
        .flush_pc_o         (flush_pc_o),
        .perf_pred_cnt_o    (perf_pred_cnt_o),
        .perf_mispred_cnt_o (perf_mispred_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time expired, want $finish");
        $fatal(1);
    end

    function automatic logic [3:0] sat(input int n);
`ifdef IBEX_BP_PERF_CNT_EN
        return (n > 15) ? 4'hF : 4'(n);
`else
        return 4'h0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic comp,
                         input logic tk, input logic [31:0] tgt);
        fetch_valid_i      = 1'b1;
        fetch_pc_i         = pc;
        fetch_compressed_i = comp;
        predict_taken_i    = tk;
        predict_pc_i       = tgt;
    endtask

    task automatic no_fetch();
        fetch_valid_i      = 1'b0;
        fetch_compressed_i = 1'b0;
        predict_taken_i    = 1'b0;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt,
                           input logic fl, input logic [31:0] fpc);
        fl_t e;
        resolve_valid_i  = 1'b1;
        resolve_taken_i  = tk;
        resolve_target_i = tgt;
        e.fl = fl;
        e.pc = fpc;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        no_fetch();
        fetch_pc_i       = '0;
        predict_pc_i     = '0;
        redirect_ready_i = 1'b1;
        resolve_valid_i  = 1'b0;
        resolve_taken_i  = 1'b0;
        resolve_target_i = '0;
        kill_i           = 1'b0;
        tick();
        tick();
        checks++;
        if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_redirect: got %b/%h want 0/0",
                     redirect_o, redirect_pc_o);
        end
        checks++;
        if (flush_o !== 1'b0 || flush_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_flush: got %b/%h want 0/0",
                     flush_o, flush_pc_o);
        end
        checks++;
        if (perf_pred_cnt_o !== 4'h0 || perf_mispred_cnt_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_cnt: got %h/%h want 0/0",
                     perf_pred_cnt_o, perf_mispred_cnt_o);
        end
        rst_i = 1'b0;
        tick();
        checks++;
        if (fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", fetch_ready_o);
        end
    endtask

    task automatic test_not_taken();
        fl_t e;
        fetch(32'h100, 1'b0, 1'b0, 32'h0);
        tick();
        no_fetch();
        checks++;
        if (redirect_o !== 1'b0) begin
            errors++;
            $display("FAIL nt_redirect: got %b want 0", redirect_o);
        end
        resolve(1'b0, 32'h0, 1'b0, 32'h0);
        pred_m++;
        tick();
        resolve_valid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (flush_o !== e.fl) begin
            errors++;
            $display("FAIL nt_flush: got %b want %b", flush_o, e.fl);
        end
        fetch(32'h104, 1'b0, 1'b0, 32'h0);
        tick();
        no_fetch();
        checks++;
        if (fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL nt_empty: ready got %b want 1", fetch_ready_o);
        end
        resolve(1'b0, 32'h0, 1'b0, 32'h0);
        pred_m++;
        tick();
        resolve_valid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (flush_o !== e.fl) begin
            errors++;
            $display("FAIL nt_flush2: got %b want %b", flush_o, e.fl);
        end
    endtask

    task automatic test_redirect_hold();
        fl_t e;
        redirect_ready_i = 1'b0;
        fetch(32'h100, 1'b0, 1'b1, 32'h80);
        tick();
        no_fetch();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h80 ||
                fetch_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: redir=%b pc=%h rdy=%b want 1/80/0",
                         i, redirect_o, redirect_pc_o, fetch_ready_o);
            end
            if (i == 3) redirect_ready_i = 1'b1;
            tick();
        end
        checks++;
        if (redirect_o !== 1'b0 || fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_end: redir=%b rdy=%b want 0/1",
                     redirect_o, fetch_ready_o);
        end
        resolve(1'b1, 32'h80, 1'b0, 32'h0);
        pred_m++;
        tick();
        resolve_valid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (flush_o !== e.fl) begin
            errors++;
            $display("FAIL hold_flush: got %b want %b", flush_o, e.fl);
        end
    endtask

    task automatic test_recovery();
        fl_t e;
        fetch(32'h200, 1'b1, 1'b0, 32'h0);
        tick();
        no_fetch();
        resolve(1'b1, 32'h300, 1'b1, 32'h300);
        pred_m++;
        mis_m++;
        tick();
        resolve_valid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (flush_o !== e.fl || flush_pc_o !== e.pc) begin
            errors++;
            $display("FAIL rec_taken: got %b/%h want %b/%h",
                     flush_o, flush_pc_o, e.fl, e.pc);
        end
        checks++;
        if (fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rec_ready: got %b want 1", fetch_ready_o);
        end
        tick();
        checks++;
        if (flush_o !== 1'b0) begin
            errors++;
            $display("FAIL rec_pulse: got %b want 0", flush_o);
        end
        fetch(32'h400, 1'b0, 1'b1, 32'h500);
        tick();
        no_fetch();
        tick();
        resolve(1'b0, 32'h0, 1'b1, 32'h404);
        pred_m++;
        mis_m++;
        tick();
        resolve_valid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (flush_o !== e.fl || flush_pc_o !== e.pc) begin
            errors++;
            $display("FAIL rec_nt: got %b/%h want %b/%h",
                     flush_o, flush_pc_o, e.fl, e.pc);
        end
        tick();
    endtask

    task automatic test_full();
        fl_t e;
        fetch(32'h10, 1'b0, 1'b0, 32'h0);
        tick();
        fetch(32'h14, 1'b0, 1'b0, 32'h0);
        tick();
        fetch(32'h18, 1'b0, 1'b0, 32'h0);
        checks++;
        if (fetch_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b want 0", fetch_ready_o);
        end
        resolve(1'b0, 32'h0, 1'b0, 32'h0);
        pred_m++;
        tick();
        no_fetch();
        resolve_valid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (flush_o !== e.fl || fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: flush=%b rdy=%b want %b/1",
                     flush_o, fetch_ready_o, e.fl);
        end
        resolve(1'b0, 32'h0, 1'b0, 32'h0);
        pred_m++;
        tick();
        resolve_valid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (flush_o !== e.fl) begin
            errors++;
            $display("FAIL full_pop2: got %b want %b", flush_o, e.fl);
        end
    endtask

    task automatic mispred_pending(input logic kill);
        fl_t e;
        redirect_ready_i = 1'b0;
        fetch(32'h10, 1'b0, 1'b0, 32'h0);
        tick();
        fetch(32'h14, 1'b0, 1'b1, 32'h40);
        tick();
        no_fetch();
        checks++;
        if (redirect_o !== 1'b1) begin
            errors++;
            $display("FAIL mp_pend_%0b: redir got %b want 1",
                     kill, redirect_o);
        end
        resolve(1'b1, 32'h900, !kill, 32'h900);
        kill_i = kill;
        pred_m++;
        mis_m++;
        tick();
        resolve_valid_i = 1'b0;
        kill_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (flush_o !== e.fl || (e.fl && flush_pc_o !== e.pc)) begin
            errors++;
            $display("FAIL mp_flush_%0b: got %b/%h want %b/%h",
                     kill, flush_o, flush_pc_o, e.fl, e.pc);
        end
        checks++;
        if (redirect_o !== 1'b0 || fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mp_state_%0b: redir=%b rdy=%b want 0/1",
                     kill, redirect_o, fetch_ready_o);
        end
        fetch(32'h20, 1'b0, 1'b0, 32'h0);
        tick();
        no_fetch();
        checks++;
        if (fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mp_empty_%0b: ready got %b want 1",
                     kill, fetch_ready_o);
        end
        resolve(1'b0, 32'h0, 1'b0, 32'h0);
        pred_m++;
        tick();
        resolve_valid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (flush_o !== e.fl) begin
            errors++;
            $display("FAIL mp_after_%0b: got %b want %b",
                     kill, flush_o, e.fl);
        end
        redirect_ready_i = 1'b1;
    endtask

    task automatic test_mispredict_redirect();
        mispred_pending(1'b0);
        mispred_pending(1'b1);
        checks++;
        if (perf_pred_cnt_o !== sat(pred_m) ||
            perf_mispred_cnt_o !== sat(mis_m)) begin
            errors++;
            $display("FAIL cnt_mid: got %h/%h want %h/%h",
                     perf_pred_cnt_o, perf_mispred_cnt_o,
                     sat(pred_m), sat(mis_m));
        end
    endtask

    task automatic test_perf();
        fl_t e;
        int  bad = 0;
        for (int i = 0; i < 20; i++) begin
            fetch(32'h2000 + 32'(i) * 4, 1'b0, 1'b0, 32'h0);
            tick();
            no_fetch();
            resolve(1'b1, 32'h1000 + 32'(i) * 4,
                    1'b1, 32'h1000 + 32'(i) * 4);
            pred_m++;
            mis_m++;
            tick();
            resolve_valid_i = 1'b0;
            e = sbq.pop_front();
            if (flush_o !== e.fl || flush_pc_o !== e.pc) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL perf_flush: %0d bad flushes of 20, want 0", bad);
        end
        checks++;
        if (perf_pred_cnt_o !== sat(pred_m) ||
            perf_mispred_cnt_o !== sat(mis_m)) begin
            errors++;
            $display("FAIL perf_sat: got %h/%h want %h/%h",
                     perf_pred_cnt_o, perf_mispred_cnt_o,
                     sat(pred_m), sat(mis_m));
        end
    endtask

    task automatic test_reset_mid();
        fl_t e;
        redirect_ready_i = 1'b0;
        fetch(32'h100, 1'b0, 1'b1, 32'h80);
        tick();
        no_fetch();
        resolve_valid_i  = 1'b1;
        resolve_taken_i  = 1'b0;
        resolve_target_i = 32'h0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        resolve_valid_i = 1'b0;
        pred_m = 0;
        mis_m  = 0;
        checks++;
        if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0 ||
            flush_o !== 1'b0 || flush_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: redir=%b/%h flush=%b/%h want all 0",
                     redirect_o, redirect_pc_o, flush_o, flush_pc_o);
        end
        checks++;
        if (perf_pred_cnt_o !== 4'h0 || perf_mispred_cnt_o !== 4'h0 ||
            fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_cnt: cnt=%h/%h rdy=%b want 0/0/1",
                     perf_pred_cnt_o, perf_mispred_cnt_o, fetch_ready_o);
        end
        redirect_ready_i = 1'b1;
        fetch(32'h30, 1'b0, 1'b0, 32'h0);
        tick();
        no_fetch();
        checks++;
        if (fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_empty: ready got %b want 1",
                     fetch_ready_o);
        end
        resolve(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        resolve_valid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (flush_o !== e.fl) begin
            errors++;
            $display("FAIL rst_mid_flush: got %b want %b", flush_o, e.fl);
        end
    endtask

    initial begin
        test_reset();
        test_not_taken();
        test_redirect_hold();
        test_recovery();
        test_full();
        test_mispredict_redirect();
        test_perf();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
